mealy_input_stage: RTL and testbench
====================================

// Module: mealy_input_stage
// PURPOSE
//  Input conditioner directly upstream of the 3-state Mealy step machine.
//  Synchronises and debounces 2 raw switches and a raw step button.
//  Drives the FSM's 2-bit input symbol (sw_out) and a 1-cycle step strobe (step_pulse -> ctrl_in).
//  Guarantees sw_out is stable in every cycle step_pulse is high; counts steps issued.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable synced samples required to accept a new level (>=2)
//  CNT_W            8   width of step_count
//  AUTO_PERIOD      1000  cycles between auto steps (only with MEALY_AUTOSTEP_EN)
// PORTS
//  clk         in   1      single clock, all flops rising-edge
//  reset_n     in   1      asynchronous, active-low reset
//  sw_raw      in   2      raw switch levels, asynchronous to clk
//  btn_raw     in   1      raw step button, asynchronous, active-high
//  auto_mode   in   1      1 = timer stepping (port exists only with MEALY_AUTOSTEP_EN)
//  sw_out      out  2      debounced switch symbol -> FSM sw_in
//  step_pulse  out  1      single-cycle step strobe -> FSM ctrl_in
//  step_count  out  CNT_W  steps issued since reset, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Reset (async assert, sync release via flops):
//  - All sync flops, debounced levels, sw_out, step_pulse and step_count = 0.
//  - btn_armed = 0.
//  Sync: each raw bit passes through 2 flops (s1, s2); only s2 is used downstream.
//  Debounce, per bit:
//  - cnt resets to 0 whenever s2 == deb.
//  - Otherwise cnt increments; when cnt == DEBOUNCE_CYCLES-1 and s2 != deb, deb <= s2 and cnt <= 0.
//  - Any glitch shorter than DEBOUNCE_CYCLES samples causes no change.
//  Step edge:
//  - step_pulse <= deb_btn & ~deb_btn_q & btn_armed; it is high for exactly 1 cycle per accepted press.
//  - Latency: raw rise held steady -> step_pulse high after edge DEBOUNCE_CYCLES+3, counting from the first edge that samples it.
//  - Release and bounce produce no pulse; a held button produces exactly one pulse.
//  Arming: btn_armed sets once deb_btn is seen 0 after reset. A button held through reset release produces no pulse until it is released and pressed again.
//  sw_out update:
//  - sw_out <= deb_sw, except in a cycle where step_pulse is being asserted.
//  - In that case the update is deferred exactly 1 cycle, so the FSM samples the pre-step symbol.
//  step_count: +1 on every cycle step_pulse is high, modulo 2^CNT_W.
//  Reset mid-operation: pending debounce counts, a deferred sw_out update and any in-flight pulse are all discarded.
// CONFIGURATION
//  Macro MEALY_AUTOSTEP_EN:
//  - Defined: adds auto_mode and a free-running period counter, cleared when auto_mode=0.
//  - While auto_mode=1, step_pulse fires when period count == AUTO_PERIOD-1, then the count wraps to 0.
//  - While auto_mode=1, button pulses are suppressed (the debouncer keeps running).
//  - First auto pulse comes AUTO_PERIOD cycles after auto_mode rises; the sw_out deferral rule applies unchanged.
//  - Undefined: no auto_mode port and no period counter; steps come from the button only.
// STRUCTURE
//  Package mealy_io_pkg:
//  - SW_W = 2 and typedef logic [SW_W-1:0] sym_t, shared with the Mealy FSM.
//  - Default DEBOUNCE_CYCLES.
//  Sub-module debounce_cell (2-flop sync + counter + deb level), instantiated 3 times: sw[1], sw[0], btn.
//  Edge detect, arming, deferral and counters live in the top level.
// TESTING (DEBOUNCE_CYCLES=4)
//  - Reset with btn_raw=1, sw_raw=2'b11, release reset_n, hold 20 cycles -> step_pulse never 1, step_count=0, sw_out=3 after edge 6.
//  - btn_raw 0->1 held -> step_pulse=1 only in the cycle after edge 7; step_count=1.
//  - btn_raw pulses high 3 cycles, then low -> no step_pulse; step_count unchanged.
//  - sw_raw 0->2 timed so deb_sw changes in the same cycle as a step -> FSM samples sw_out=0 with step_pulse=1; sw_out=2 one cycle later.
//  - step_count=255 plus one press -> step_count=0. reset_n low mid-debounce -> all outputs 0 immediately (asynchronous).
//  - MEALY_AUTOSTEP_EN, AUTO_PERIOD=5, auto_mode=1 for 20 cycles -> 4 pulses spaced 5 cycles; button presses ignored.

Source files
------------

// File: rtl/mealy_io_pkg.sv
// Shared types and defaults for the Mealy step machine and its input conditioner.
package mealy_io_pkg;

    localparam int unsigned SW_W                = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

    typedef logic [SW_W-1:0] sym_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One-bit two-flop synchroniser followed by a stable-sample debouncer.
module debounce_cell
    import mealy_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_sync,
    output logic o_deb,
    output logic o_deb_d
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

    logic          r_s1;
    logic          r_s2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;
    logic          w_deb_d;

    always_comb begin
        w_deb_d = r_deb;
        w_cnt_d = '0;
        if (r_s2 != r_deb) begin
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                w_deb_d = r_s2;
            end else begin
                w_cnt_d = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1  <= i_raw;
            r_s2  <= r_s1;
            r_deb <= w_deb_d;
            r_cnt <= w_cnt_d;
        end
    end

    assign o_sync  = r_s2;
    assign o_deb   = r_deb;
    assign o_deb_d = w_deb_d;

endmodule

// File: rtl/mealy_input_stage.sv
// Input conditioner ahead of the Mealy step FSM: debounced symbol, step strobe, step counter.
// Define MEALY_AUTOSTEP_EN to add the auto_mode port and timer-driven stepping.
module mealy_input_stage
    import mealy_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = 8
`ifdef MEALY_AUTOSTEP_EN
    ,
    parameter int unsigned AUTO_PERIOD     = 1000
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  sym_t             sw_raw,
    input  logic             btn_raw,
`ifdef MEALY_AUTOSTEP_EN
    input  logic             auto_mode,
`endif
    output sym_t             sw_out,
    output logic             step_pulse,
    output logic [CNT_W-1:0] step_count
);

    sym_t             w_sw_sync;
    sym_t             w_sw_deb;
    sym_t             w_sw_deb_d;
    logic             w_btn_sync;
    logic             w_btn_deb;
    logic             w_btn_deb_d;
    logic             w_btn_edge;
    logic             w_step_d;
    logic             w_unused;

    logic [1:0]       r_prime;
    logic             r_armed;
    logic             r_btn_q;
    logic             r_step_pulse;
    sym_t             r_sw_out;
    logic [CNT_W-1:0] r_step_count;

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .i_raw   (sw_raw[i]),
            .o_sync  (w_sw_sync[i]),
            .o_deb   (w_sw_deb[i]),
            .o_deb_d (w_sw_deb_d[i])
        );
    end

    debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (btn_raw),
        .o_sync  (w_btn_sync),
        .o_deb   (w_btn_deb),
        .o_deb_d (w_btn_deb_d)
    );

    assign w_unused   = ^{w_sw_sync, w_sw_deb, w_btn_deb_d};
    assign w_btn_edge = w_btn_deb & ~r_btn_q & r_armed;

`ifdef MEALY_AUTOSTEP_EN
    localparam int unsigned PW = cnt_width(AUTO_PERIOD);

    logic [PW-1:0] r_period;
    logic          w_auto_fire;

    assign w_auto_fire = auto_mode && (r_period == PW'(AUTO_PERIOD - 1));
    // Button edges are ignored while the timer owns the strobe.
    assign w_step_d    = auto_mode ? w_auto_fire : w_btn_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period <= '0;
        end else if (!auto_mode || w_auto_fire) begin
            r_period <= '0;
        end else begin
            r_period <= r_period + 1'b1;
        end
    end
`else
    assign w_step_d = w_btn_edge;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prime      <= '0;
            r_armed      <= 1'b0;
            r_btn_q      <= 1'b0;
            r_step_pulse <= 1'b0;
            r_sw_out     <= '0;
            r_step_count <= '0;
        end else begin
            // Arm only on a real released sample, not on the reset value still in the sync pipe.
            r_prime <= {r_prime[0], 1'b1};
            if (&r_prime && !w_btn_sync && !w_btn_deb) begin
                r_armed <= 1'b1;
            end
            r_btn_q      <= w_btn_deb;
            r_step_pulse <= w_step_d;
            // Hold the symbol while the strobe is high so the FSM samples the pre-step value.
            if (!w_step_d) begin
                r_sw_out <= w_sw_deb_d;
            end
            if (r_step_pulse) begin
                r_step_count <= r_step_count + 1'b1;
            end
        end
    end

    assign sw_out     = r_sw_out;
    assign step_pulse = r_step_pulse;
    assign step_count = r_step_count;

endmodule

// File: tb/tb_mealy_input_stage.sv
// Scoreboard bench for mealy_input_stage with DEBOUNCE_CYCLES=4.
module tb_mealy_input_stage;

    localparam int unsigned DC    = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       sw_raw = 2'b00;
    logic             btn_raw = 1'b0;
`ifdef MEALY_AUTOSTEP_EN
    logic             auto_mode = 1'b0;
`endif
    logic [1:0]       sw_out;
    logic             step_pulse;
    logic [CNT_W-1:0] step_count;

    typedef struct packed {
        logic [1:0]       sw;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mealy_input_stage #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_raw     (sw_raw),
        .btn_raw    (btn_raw),
`ifdef MEALY_AUTOSTEP_EN
        .auto_mode  (auto_mode),
`endif
        .sw_out     (sw_out),
        .step_pulse (step_pulse),
        .step_count (step_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_step(input logic [1:0] sw, input logic [CNT_W-1:0] c);
        exp_t e;
        e.sw  = sw;
        e.cnt = c;
        q.push_back(e);
    endtask

    task automatic press(input logic [1:0] sw, input logic [CNT_W-1:0] c);
        expect_step(sw, c);
        btn_raw = 1'b1;
        repeat (10) tick();
        btn_raw = 1'b0;
        repeat (10) tick();
    endtask

    // Monitor: every strobe must match the oldest expected step.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && step_pulse === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got step_pulse=1 expected 0 (count %0d) at %0t",
                         step_count, $time);
            end else begin
                e = q.pop_front();
                chk("pulse_sw_out", 32'(sw_out), 32'(e.sw));
                chk("pulse_count", 32'(step_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        // Button and switches held high through reset.
        sw_raw  = 2'b11;
        btn_raw = 1'b1;
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_sw_out", 32'(sw_out), 32'd0);
        chk("rst_pulse", 32'(step_pulse), 32'd0);
        chk("rst_count", 32'(step_count), 32'd0);
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("held_sw_out", 32'(sw_out), (k >= 6) ? 32'd3 : 32'd0);
            chk("held_no_pulse", 32'(step_pulse), 32'd0);
        end
        chk("held_count", 32'(step_count), 32'd0);

        // Release, then a clean press: strobe only after edge 7.
        btn_raw = 1'b0;
        repeat (10) tick();
        expect_step(2'b11, 8'd0);
        btn_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("press_edge", 32'(step_pulse), (k == 7) ? 32'd1 : 32'd0);
        end
        chk("press_count", 32'(step_count), 32'd1);
        btn_raw = 1'b0;
        repeat (10) tick();

        // Three-sample glitch must be rejected.
        btn_raw = 1'b1;
        repeat (3) tick();
        btn_raw = 1'b0;
        repeat (12) tick();
        chk("glitch_count", 32'(step_count), 32'd1);

        // Switch change accepted in the same cycle as the step: symbol update deferred.
        sw_raw = 2'b00;
        repeat (10) tick();
        chk("sw_zero", 32'(sw_out), 32'd0);
        expect_step(2'b00, 8'd1);
        btn_raw = 1'b1;
        tick();
        sw_raw = 2'b10;
        for (int k = 2; k <= 10; k++) begin
            tick();
            chk("defer_sw_out", 32'(sw_out), (k >= 8) ? 32'd2 : 32'd0);
            chk("defer_pulse", 32'(step_pulse), (k == 7) ? 32'd1 : 32'd0);
        end
        chk("defer_count", 32'(step_count), 32'd2);
        btn_raw = 1'b0;
        repeat (10) tick();

        // Run the counter up to 255 and wrap it.
        for (int c = 2; c <= 255; c++) begin
            press(2'b10, CNT_W'(c));
        end
        chk("wrap_count", 32'(step_count), 32'd0);
        press(2'b10, 8'd0);
        chk("post_wrap_count", 32'(step_count), 32'd1);

        // Asynchronous reset in the middle of a debounce.
        btn_raw = 1'b1;
        sw_raw  = 2'b01;
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_sw_out", 32'(sw_out), 32'd0);
        chk("async_pulse", 32'(step_pulse), 32'd0);
        chk("async_count", 32'(step_count), 32'd0);
        btn_raw = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        // Debounce restarts from zero after release.
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("restart_sw_out", 32'(sw_out), (k >= 6) ? 32'd1 : 32'd0);
        end
        repeat (6) tick();
        chk("restart_count", 32'(step_count), 32'd0);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
